// File: rtl/regfile_rename_ckpt_if.sv
// Dispatcher / ROB facing bus of the rename register file: operand reads,
// destination rename, commit, checkpoint save/release/restore and flush.
interface regfile_rename_ckpt_if #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int ROB_W  = 4,
    parameter int RPORTS = 2,
    parameter int NCKPT  = 4
);
    localparam int REG_W = $clog2(NREG);
    localparam int CK_W  = $clog2(NCKPT);

    logic                    rdy_in;
    logic                    rename_en_in;
    logic [REG_W-1:0]        rename_rd_in;
    logic [ROB_W-1:0]        rename_tag_in;
    logic [RPORTS*REG_W-1:0] rd_addr_in;
    logic [RPORTS*XLEN-1:0]  rd_val_out;
    logic [RPORTS-1:0]       rd_busy_out;
    logic [RPORTS*ROB_W-1:0] rd_tag_out;
    logic                    commit_en_in;
    logic [REG_W-1:0]        commit_rd_in;
    logic [ROB_W-1:0]        commit_tag_in;
    logic [XLEN-1:0]         commit_val_in;
    logic                    ckpt_save_in;
    logic [CK_W-1:0]         ckpt_id_out;
    logic                    ckpt_full_out;
    logic                    ckpt_release_in;
    logic                    ckpt_restore_in;
    logic [CK_W-1:0]         ckpt_restore_id_in;
    logic                    flush_in;

    // Register file side
    modport slave (
        input  rdy_in, rename_en_in, rename_rd_in, rename_tag_in, rd_addr_in,
        input  commit_en_in, commit_rd_in, commit_tag_in, commit_val_in,
        input  ckpt_save_in, ckpt_release_in, ckpt_restore_in, ckpt_restore_id_in,
        input  flush_in,
        output rd_val_out, rd_busy_out, rd_tag_out, ckpt_id_out, ckpt_full_out
    );

    // Dispatcher / ROB side
    modport master (
        output rdy_in, rename_en_in, rename_rd_in, rename_tag_in, rd_addr_in,
        output commit_en_in, commit_rd_in, commit_tag_in, commit_val_in,
        output ckpt_save_in, ckpt_release_in, ckpt_restore_in, ckpt_restore_id_in,
        output flush_in,
        input  rd_val_out, rd_busy_out, rd_tag_out, ckpt_id_out, ckpt_full_out
    );
endinterface

// File: rtl/regfile_rename_ckpt.sv
// Architectural register file with a rename (busy/tag) table and a ring of
// rename-map checkpoints. A mispredict restores the map of its checkpoint;
// a flush clears every pending producer.
module regfile_rename_ckpt #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int ROB_W  = 4,
    parameter int RPORTS = 2,
    parameter int NCKPT  = 4
) (
    input logic                  clk_in,
    input logic                  rst_in,
    regfile_rename_ckpt_if.slave bus
);
    localparam int REG_W = $clog2(NREG);
    localparam int CK_W  = $clog2(NCKPT);

    // Architectural state and live rename map
    logic [XLEN-1:0]  r_regs [NREG];
    logic [NREG-1:0]  r_busy;
    logic [ROB_W-1:0] r_tag  [NREG];

    // Checkpoint ring: busy/tag snapshots plus wrap-flagged pointers
    logic [NREG-1:0]  r_snap_busy [NCKPT];
    logic [ROB_W-1:0] r_snap_tag  [NCKPT][NREG];
    logic [CK_W:0]    r_head;
    logic [CK_W:0]    r_tail;

    logic [CK_W:0]    w_count;
    logic             w_full;
    logic             w_commit;
    logic             w_rename;
    logic             w_restore;
    logic             w_rename_ok;
    logic             w_save_ok;
    logic             w_release_ok;
    logic [CK_W-1:0]  w_restore_off;
    logic [NCKPT-1:0] w_snap_clr;
    logic [NREG-1:0]  w_busy_nxt;
    logic [ROB_W-1:0] w_tag_nxt [NREG];

    // Register 0 is hard-wired, so renames and commits to it are no-ops.
    assign w_count       = r_tail - r_head;
    assign w_full        = (w_count == (CK_W+1)'(NCKPT));
    assign w_commit      = bus.commit_en_in && (bus.commit_rd_in != '0);
    assign w_rename      = bus.rename_en_in && (bus.rename_rd_in != '0);
    assign w_restore     = bus.ckpt_restore_in && !bus.flush_in;
    assign w_rename_ok   = w_rename && !bus.flush_in && !w_restore;
    assign w_save_ok     = bus.ckpt_save_in && !w_full && !bus.flush_in && !w_restore;
    assign w_release_ok  = bus.ckpt_release_in && (w_count != '0) && !bus.flush_in;
    // Distance of the restored slot from the oldest checkpoint; the new tail
    // lands on that slot, freeing it and everything younger.
    assign w_restore_off = bus.ckpt_restore_id_in - r_head[CK_W-1:0];

    assign bus.ckpt_id_out   = r_tail[CK_W-1:0];
    assign bus.ckpt_full_out = w_full;

    // Next-state live map: base (live or restored), commit clear, rename, flush
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
        w_busy_nxt = r_busy;
        for (int r = 0; r < NREG; r++) w_tag_nxt[r] = r_tag[r];
        if (w_restore) begin
            w_busy_nxt = r_snap_busy[bus.ckpt_restore_id_in];
            for (int r = 0; r < NREG; r++) w_tag_nxt[r] = r_snap_tag[bus.ckpt_restore_id_in][r];
        end
        if (w_commit && (w_tag_nxt[bus.commit_rd_in] == bus.commit_tag_in) &&
            !(w_rename_ok && (bus.rename_rd_in == bus.commit_rd_in)))
            w_busy_nxt[bus.commit_rd_in] = 1'b0;
        if (w_rename_ok) begin
            w_busy_nxt[bus.rename_rd_in] = 1'b1;
            w_tag_nxt[bus.rename_rd_in]  = bus.rename_tag_in;
        end
        if (bus.flush_in) w_busy_nxt = '0;
    end

    // Which live checkpoints see this cycle's commit as their producer
    always_comb begin
        w_snap_clr = '0;
        for (int s = 0; s < NCKPT; s++) begin
            if (w_commit &&
                ({1'b0, CK_W'(s) - r_head[CK_W-1:0]} < w_count) &&
                (r_snap_tag[s][bus.commit_rd_in] == bus.commit_tag_in))
                w_snap_clr[s] = 1'b1;
        end
    end

    // Combinational operand read with same-cycle rename/commit bypass
    always_comb begin
        bus.rd_val_out  = '0;
        bus.rd_busy_out = '0;
        bus.rd_tag_out  = '0;
        for (int p = 0; p < RPORTS; p++) begin
            logic [REG_W-1:0] w_addr;
            w_addr = bus.rd_addr_in[p*REG_W +: REG_W];
            if (w_commit && (bus.commit_rd_in == w_addr))
                bus.rd_val_out[p*XLEN +: XLEN] = bus.commit_val_in;
            else
                bus.rd_val_out[p*XLEN +: XLEN] = r_regs[w_addr];
            if (w_rename && (bus.rename_rd_in == w_addr)) begin
                bus.rd_busy_out[p]             = 1'b1;
                bus.rd_tag_out[p*ROB_W +: ROB_W] = bus.rename_tag_in;
            end else if (w_commit && (bus.commit_rd_in == w_addr) &&
                         (r_tag[w_addr] == bus.commit_tag_in)) begin
                bus.rd_busy_out[p]             = 1'b0;
                bus.rd_tag_out[p*ROB_W +: ROB_W] = r_tag[w_addr];
            end else begin
                bus.rd_busy_out[p]             = r_busy[w_addr];
                bus.rd_tag_out[p*ROB_W +: ROB_W] = r_tag[w_addr];
            end
        end
    end

    // Architectural values: commit writes even during a flush
    always_ff @(posedge clk_in or negedge rst_in) begin
        // NOTE: register arrays are reset explicitly because reads must return 0 straight out of reset.
        if (!rst_in) begin
            for (int r = 0; r < NREG; r++) r_regs[r] <= '0;
        end else if (bus.rdy_in && w_commit) begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            r_regs[bus.commit_rd_in] <= bus.commit_val_in;
        end
    end

    // Live rename map
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy <= '0;
            for (int r = 0; r < NREG; r++) r_tag[r] <= '0;
        end else if (bus.rdy_in) begin
            r_busy <= w_busy_nxt;
            for (int r = 0; r < NREG; r++) r_tag[r] <= w_tag_nxt[r];
        end
    end

    // Checkpoint snapshots: commit clears in live slots, save into the tail slot
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int s = 0; s < NCKPT; s++) begin
                r_snap_busy[s] <= '0;
                for (int r = 0; r < NREG; r++) r_snap_tag[s][r] <= '0;
            end
        end else if (bus.rdy_in && !bus.flush_in) begin
            for (int s = 0; s < NCKPT; s++) begin
                if (w_snap_clr[s]) r_snap_busy[s][bus.commit_rd_in] <= 1'b0;
            end
            if (w_save_ok) begin
                r_snap_busy[r_tail[CK_W-1:0]] <= w_busy_nxt;
                for (int r = 0; r < NREG; r++) r_snap_tag[r_tail[CK_W-1:0]][r] <= w_tag_nxt[r];
            end
        end
    end

    // Ring pointers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (bus.rdy_in) begin
            if (bus.flush_in) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                if (w_release_ok) r_head <= r_head + 1'b1;
                if (w_restore)    r_tail <= r_head + {1'b0, w_restore_off};
                else if (w_save_ok) r_tail <= r_tail + 1'b1;
            end
        end
    end
endmodule
